fft_bitrev_reorder: RTL

Output reorder buffer for the SDF radix-2^2 FFT pipeline. It consumes the FFT's bit-reversed-order output stream and re-emits each N-sample frame in natural order. The block uses a ping-pong pair of N-deep complex buffers, so consecutive frames stream back-to-back without stalls. It sits directly after the last FFT stage and before the PUSCH post-FFT processing.

---
 rtl/fft_bitrev_reorder.sv | 75 +++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT frames into natural order
module fft_bitrev_reorder #(
  parameter int N     = 256,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_first
);
  function automatic int log2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  localparam int LOG_N = log2(N);
  typedef enum logic {IDLE, READ} state_t;
  state_t           state;
  logic [LOG_N-1:0] wr_cnt, wr_addr, rd_cnt;
  logic             wr_bank, rd_bank, frame_done;
  logic [2*WIDTH-1:0] mem [2*N];
  logic wr;
  assign wr = on & di_en;
  for (genvar b = 0; b < LOG_N; b++) begin : g_rev
    assign wr_addr[b] = wr_cnt[LOG_N-1-b];
  end
  always_ff @(posedge clk)
    if (wr) mem[{wr_bank, wr_addr}] <= {di_re, di_im};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wr && (&wr_cnt);
      wr_cnt     <= !on ? '0 : di_en ? wr_cnt + 1'b1 : wr_cnt;
      if (wr && (&wr_cnt)) wr_bank <= ~wr_bank;
    end
  // the completed bank is always the one the writer just left
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      do_en    <= 1'b0;
      do_first <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
    end else begin
      do_en    <= state == READ;
      do_first <= state == READ && rd_cnt == '0;
      if (state == READ) {do_re, do_im} <= mem[{rd_bank, rd_cnt}];
      if (state == IDLE) begin
        if (frame_done) begin
          state   <= READ;
          rd_bank <= ~wr_bank;
          rd_cnt  <= '0;
        end
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
        if (&rd_cnt) begin
          if (frame_done) rd_bank <= ~wr_bank;
          else state <= IDLE;
        end
      end
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(frame_done && state == READ && !(&rd_cnt)));
endmodule
